// File: rtl/pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline control blocks
// (hazard sequencer, hazard detect, forwarding unit).
package pipe_pkg;

  typedef enum logic {S_RUN, S_MUL} hz_state_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic en;
    logic bubble;
    logic flush;
  } stage_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-sequencer bundle: ID/EX register info in, per-stage strobes and
// the stall performance counter out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_is_mul;
  logic             br_taken;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             mul_start;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_count;

  // Sequencer side
  modport slave (
    input  id_rn, id_rm, id_use_rn, id_use_rm,
    input  ex_memread, ex_rd, ex_is_mul, br_taken,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
    output exmem_bubble, mul_start, mul_busy, stall_count
  );

  // Pipeline side
  modport master (
    output id_rn, id_rm, id_use_rn, id_use_rm,
    output ex_memread, ex_rd, ex_is_mul, br_taken,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
    input  exmem_bubble, mul_start, mul_busy, stall_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: an LDUR in EX whose destination is read
// by the instruction in ID. XZR is never a real dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_use_rn,
  input  logic       id_use_rm,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rn_hit;
  logic rm_hit;

  always_comb begin
    rn_hit   = id_use_rn && (id_rn == ex_rd);
    rm_hit   = id_use_rm && (id_rm == ex_rd);
    load_use = ex_memread && (ex_rd != XZR) && (rn_hit || rm_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// LEGv8 5-stage pipeline sequencer: MUL occupancy stall > load-use stall >
// taken-branch flush, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  hz_state_t        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c;
  logic idex_bubble_c, exmem_bubble_c, mul_start_c, mul_busy_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_detect u_hazard_detect (
    .id_rn      (bus.id_rn),
    .id_rm      (bus.id_rm),
    .id_use_rn  (bus.id_use_rn),
    .id_use_rm  (bus.id_use_rm),
    .ex_memread (bus.ex_memread),
    .ex_rd      (bus.ex_rd),
    .load_use   (load_use)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_en_c        = 1'b1;
    ifid_en_c      = 1'b1;
    ifid_flush_c   = 1'b0;
    idex_en_c      = 1'b1;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    mul_start_c    = 1'b0;
    mul_busy_c     = 1'b0;

    case (state_q)
      S_RUN: begin
        if (bus.ex_is_mul) begin
          mul_start_c = 1'b1;
          mul_busy_c  = 1'b1;
          if (MUL_LAT > 1) begin
            pc_en_c        = 1'b0;
            ifid_en_c      = 1'b0;
            idex_en_c      = 1'b0;
            exmem_bubble_c = 1'b1;
            cnt_d          = CNT_INIT;
            state_d        = S_MUL;
          end
        end else if (load_use) begin
          // Flush held off so a branch in ID re-resolves once the load lands.
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_bubble_c = 1'b1;
        end else if (bus.br_taken) begin
          ifid_flush_c = 1'b1;
        end
      end
      S_MUL: begin
        mul_busy_c = 1'b1;
        if (cnt_q != 4'd0) begin
          pc_en_c        = 1'b0;
          ifid_en_c      = 1'b0;
          idex_en_c      = 1'b0;
          exmem_bubble_c = 1'b1;
          cnt_d          = cnt_q - 4'd1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    stall_count_d = pc_en_c ? stall_count_q : sat_inc(stall_count_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RUN;
      cnt_q         <= 4'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Reset forces every strobe low at once, freezing the pipeline.
  assign bus.pc_en        = reset & pc_en_c;
  assign bus.ifid_en      = reset & ifid_en_c;
  assign bus.ifid_flush   = reset & ifid_flush_c;
  assign bus.idex_en      = reset & idex_en_c;
  assign bus.idex_bubble  = reset & idex_bubble_c;
  assign bus.exmem_bubble = reset & exmem_bubble_c;
  assign bus.mul_start    = reset & mul_start_c;
  assign bus.mul_busy     = reset & mul_busy_c;
  assign bus.stall_count  = stall_count_q;

endmodule
